// File: rtl/run_controller_if.sv
// Command channel from the debug/command source into the run controller.
// A command is taken on any cycle where cmd_valid and cmd_ready are both high.
interface run_controller_if #(
  parameter int CNT_WIDTH = 32
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [2:0]           cmd;
  logic [CNT_WIDTH-1:0] cmd_arg;

  modport master (output cmd_valid, output cmd, output cmd_arg, input cmd_ready);
  modport slave  (input cmd_valid, input cmd, input cmd_arg, output cmd_ready);
endinterface

// File: rtl/run_controller.sv
// Execution controller for the 8-bit machine: stretches CPU reset, gates the CPU
// clock enable for run / step / run-N / breakpoints, and counts cycles and instructions.
module run_controller #(
  parameter int ADDR_WIDTH   = 8,
  parameter int CNT_WIDTH    = 32,
  parameter int NUM_BP       = 2,
  parameter int RESET_CYCLES = 4,
  parameter bit AUTO_RUN     = 1'b0
) (
  input  logic                         clk,
  input  logic                         reset,
  run_controller_if.slave              cmd_bus,
  input  logic [NUM_BP*ADDR_WIDTH-1:0] bp_addr,
  input  logic [NUM_BP-1:0]            bp_en,
  input  logic                         cpu_fetch,
  input  logic                         cpu_instr_done,
  input  logic [ADDR_WIDTH-1:0]        cpu_pc,
  input  logic                         cpu_halted,
  output logic                         cpu_reset,
  output logic                         cpu_clk_en,
  output logic [2:0]                   state,
  output logic [2:0]                   stop_reason,
  output logic                         stopped,
  output logic [CNT_WIDTH-1:0]         cycle_count,
  output logic [CNT_WIDTH-1:0]         instr_count
);

  localparam logic [2:0] ST_RESET  = 3'd0;
  localparam logic [2:0] ST_PAUSED = 3'd1;
  localparam logic [2:0] ST_RUN    = 3'd2;
  localparam logic [2:0] ST_STEP   = 3'd3;
  localparam logic [2:0] ST_HALTED = 3'd4;

  localparam logic [2:0] CMD_RUN        = 3'd1;
  localparam logic [2:0] CMD_STEP       = 3'd2;
  localparam logic [2:0] CMD_RUN_N      = 3'd3;
  localparam logic [2:0] CMD_PAUSE      = 3'd4;
  localparam logic [2:0] CMD_SOFT_RESET = 3'd5;

  localparam logic [2:0] WHY_NONE  = 3'd0;
  localparam logic [2:0] WHY_STEP  = 3'd1;
  localparam logic [2:0] WHY_COUNT = 3'd2;
  localparam logic [2:0] WHY_BREAK = 3'd3;
  localparam logic [2:0] WHY_HALT  = 3'd4;
  localparam logic [2:0] WHY_PAUSE = 3'd5;

  localparam int RST_CNT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RST_CNT_W-1:0] RST_LAST = RST_CNT_W'(RESET_CYCLES - 1);

  logic [2:0]           state_reg, state_next;
  logic [RST_CNT_W-1:0] rst_cnt_reg, rst_cnt_next;
  logic [CNT_WIDTH-1:0] remaining_reg, remaining_next;
  logic                 count_mode_reg, count_mode_next;
  logic                 pause_pending_reg, pause_pending_next;
  logic                 bp_skip_reg, bp_skip_next;
  logic [2:0]           stop_reason_reg, stop_reason_next;
  logic                 stopped_reg, stopped_next;
  logic [CNT_WIDTH-1:0] cycle_count_reg, cycle_count_next;
  logic [CNT_WIDTH-1:0] instr_count_reg, instr_count_next;

  logic              accept;
  logic              soft_reset;
  logic [NUM_BP-1:0] bp_match;
  logic              bp_hit;
  logic              boundary;

  assign accept     = cmd_bus.cmd_valid && cmd_bus.cmd_ready;
  assign soft_reset = accept && (cmd_bus.cmd == CMD_SOFT_RESET);

  generate
    for (genvar gi = 0; gi < NUM_BP; gi++) begin : g_bp
      assign bp_match[gi] = bp_en[gi] && (bp_addr[gi*ADDR_WIDTH +: ADDR_WIDTH] == cpu_pc);
    end
  endgenerate

  // Combinational so the breakpointed instruction is frozen at its fetch cycle.
  assign bp_hit   = (state_reg == ST_RUN) && cpu_fetch && !bp_skip_reg && (|bp_match);
  assign boundary = cpu_instr_done && cpu_clk_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg         <= ST_RESET;
      rst_cnt_reg       <= '0;
      remaining_reg     <= '0;
      count_mode_reg    <= 1'b0;
      pause_pending_reg <= 1'b0;
      bp_skip_reg       <= 1'b0;
      stop_reason_reg   <= WHY_NONE;
      stopped_reg       <= 1'b0;
      cycle_count_reg   <= '0;
      instr_count_reg   <= '0;
    end else begin
      state_reg         <= state_next;
      rst_cnt_reg       <= rst_cnt_next;
      remaining_reg     <= remaining_next;
      count_mode_reg    <= count_mode_next;
      pause_pending_reg <= pause_pending_next;
      bp_skip_reg       <= bp_skip_next;
      stop_reason_reg   <= stop_reason_next;
      stopped_reg       <= stopped_next;
      cycle_count_reg   <= cycle_count_next;
      instr_count_reg   <= instr_count_next;
    end
  end

  always_comb begin
    state_next         = state_reg;
    rst_cnt_next       = rst_cnt_reg;
    remaining_next     = remaining_reg;
    count_mode_next    = count_mode_reg;
    pause_pending_next = pause_pending_reg;
    bp_skip_next       = bp_skip_reg;
    stop_reason_next   = stop_reason_reg;
    stopped_next       = 1'b0;

    case (state_reg)
      ST_RESET: begin
        if (rst_cnt_reg == RST_LAST) begin
          state_next   = AUTO_RUN ? ST_RUN : ST_PAUSED;
          bp_skip_next = AUTO_RUN;
        end else begin
          rst_cnt_next = rst_cnt_reg + RST_CNT_W'(1);
        end
      end
      ST_PAUSED: begin
        if (accept) begin
          case (cmd_bus.cmd)
            CMD_RUN: begin
              state_next      = ST_RUN;
              count_mode_next = 1'b0;
              bp_skip_next    = 1'b1;
            end
            CMD_STEP: begin
              state_next   = ST_STEP;
              bp_skip_next = 1'b1;
            end
            CMD_RUN_N: begin
              if (cmd_bus.cmd_arg == '0) begin
                stop_reason_next = WHY_COUNT;
              end else begin
                state_next      = ST_RUN;
                count_mode_next = 1'b1;
                remaining_next  = cmd_bus.cmd_arg;
                bp_skip_next    = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        if (accept && cmd_bus.cmd == CMD_PAUSE)
          pause_pending_next = 1'b1;
        if (boundary) begin
          bp_skip_next = 1'b0;
          if (count_mode_reg)
            remaining_next = remaining_reg - CNT_WIDTH'(1);
        end
        // Stop causes in priority order; a pending PAUSE waits for a boundary.
        if (cpu_halted) begin
          state_next         = ST_HALTED;
          stop_reason_next   = WHY_HALT;
          stopped_next       = 1'b1;
          pause_pending_next = 1'b0;
        end else if (bp_hit) begin
          state_next         = ST_PAUSED;
          stop_reason_next   = WHY_BREAK;
          stopped_next       = 1'b1;
          pause_pending_next = 1'b0;
        end else if (boundary && count_mode_reg && remaining_reg == CNT_WIDTH'(1)) begin
          state_next         = ST_PAUSED;
          stop_reason_next   = WHY_COUNT;
          stopped_next       = 1'b1;
          pause_pending_next = 1'b0;
        end else if (boundary && pause_pending_reg) begin
          state_next         = ST_PAUSED;
          stop_reason_next   = WHY_PAUSE;
          stopped_next       = 1'b1;
          pause_pending_next = 1'b0;
        end
      end
      ST_STEP: begin
        if (cpu_halted) begin
          state_next       = ST_HALTED;
          stop_reason_next = WHY_HALT;
          stopped_next     = 1'b1;
        end else if (boundary) begin
          state_next       = ST_PAUSED;
          stop_reason_next = WHY_STEP;
          stopped_next     = 1'b1;
          bp_skip_next     = 1'b0;
        end
      end
      ST_HALTED: ;
      default: state_next = ST_RESET;
    endcase

    if (soft_reset) begin
      state_next         = ST_RESET;
      rst_cnt_next       = '0;
      remaining_next     = '0;
      count_mode_next    = 1'b0;
      pause_pending_next = 1'b0;
      bp_skip_next       = 1'b0;
      stop_reason_next   = WHY_NONE;
      stopped_next       = 1'b0;
    end
  end

  // Saturating counters; a soft reset clears them on its acceptance edge.
  always_comb begin
    cycle_count_next = cycle_count_reg;
    instr_count_next = instr_count_reg;
    if (soft_reset) begin
      cycle_count_next = '0;
      instr_count_next = '0;
    end else begin
      if (cpu_clk_en && cycle_count_reg != '1)
        cycle_count_next = cycle_count_reg + CNT_WIDTH'(1);
      if (boundary && instr_count_reg != '1)
        instr_count_next = instr_count_reg + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    cpu_reset         = (state_reg == ST_RESET);
    cmd_bus.cmd_ready = (state_reg != ST_RESET);
    cpu_clk_en        = ((state_reg == ST_RUN) || (state_reg == ST_STEP)) && !bp_hit;
    state             = state_reg;
    stop_reason       = stop_reason_reg;
    stopped           = stopped_reg;
    cycle_count       = cycle_count_reg;
    instr_count       = instr_count_reg;
  end

endmodule
